// File: rtl/turbo_ctrl_pkg.sv
// Shared types for the turbo decoder control blocks: recursion FSM states and
// metric vector typedefs sized for the default configuration.
package turbo_ctrl_pkg;

    localparam int BITS_DEF           = 16;
    localparam int STATES_DEF         = 4;
    localparam int OUTPUT_SYMBOLS_DEF = 4;
    localparam int ADDR_BITS_DEF      = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_e;

    typedef logic [STATES_DEF-1:0][BITS_DEF-1:0]         alpha_t;
    typedef logic [OUTPUT_SYMBOLS_DEF-1:0][BITS_DEF-1:0] branch_metric_t;

endpackage

// File: rtl/alpha_recursion_ctrl.sv
// Forward (alpha) recursion sequencer: fetches one branch-metric word per trellis
// step, issues it to the external alpha element and stores each resulting vector.
module alpha_recursion_ctrl
    import turbo_ctrl_pkg::*;
#(
    parameter int BITS           = BITS_DEF,
    parameter int STATES         = STATES_DEF,
    parameter int OUTPUT_SYMBOLS = OUTPUT_SYMBOLS_DEF,
    parameter int ADDR_BITS      = ADDR_BITS_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [ADDR_BITS-1:0]                 frame_len,
    input  logic [STATES-1:0][BITS-1:0]          alpha_init,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 bm_rd_en,
    output logic [ADDR_BITS-1:0]                 bm_rd_addr,
    input  logic [OUTPUT_SYMBOLS-1:0][BITS-1:0]  bm_rd_data,
    output logic                                 ae_in_valid,
    output logic [OUTPUT_SYMBOLS-1:0][BITS-1:0]  ae_branch_metric,
    output logic [STATES-1:0][BITS-1:0]          ae_prev_alpha,
    input  logic                                 ae_out_valid,
    input  logic [STATES-1:0][BITS-1:0]          ae_alpha,
    output logic                                 am_wr_en,
    output logic [ADDR_BITS:0]                   am_wr_addr,
    output logic [STATES-1:0][BITS-1:0]          am_wr_data,
    output state_e                               dbg_state
);

    // Handshake: every strobe (bm_rd_en, ae_in_valid, am_wr_en, done) is a
    // single-cycle pulse; bm_rd_data is consumed the cycle after bm_rd_en, and
    // ae_alpha is consumed only in the cycle ae_out_valid is high.

    state_e                    state_q, state_d;
    logic [ADDR_BITS-1:0]      k_q, k_d;
    logic [ADDR_BITS-1:0]      n_q, n_d;
    logic [STATES-1:0][BITS-1:0] prev_q, prev_d;
    logic [STATES-1:0][BITS-1:0] init_q, init_d;
    logic [ADDR_BITS:0]        k_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            n_q     <= '0;
            prev_q  <= '0;
            init_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            prev_q  <= prev_d;
            init_q  <= init_d;
        end
    end

    // One extra bit so the final step index k+1 = N never wraps at maximum N.
    assign k_next = {1'b0, k_q} + (ADDR_BITS+1)'(1);

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        n_d         = n_q;
        prev_d      = prev_q;
        init_d      = init_q;
        done        = 1'b0;
        bm_rd_en    = 1'b0;
        bm_rd_addr  = '0;
        ae_in_valid = 1'b0;
        am_wr_en    = 1'b0;
        am_wr_addr  = '0;
        am_wr_data  = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d     = frame_len;
                    init_d  = alpha_init;
                    k_d     = '0;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                am_wr_en   = 1'b1;
                am_wr_data = init_q;
                prev_d     = init_q;
                state_d    = (n_q == '0) ? ST_DONE : ST_FETCH;
            end
            ST_FETCH: begin
                bm_rd_en   = 1'b1;
                bm_rd_addr = k_q;
                state_d    = ST_ISSUE;
            end
            ST_ISSUE: begin
                ae_in_valid = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (ae_out_valid) begin
                    am_wr_en   = 1'b1;
                    am_wr_addr = k_next;
                    am_wr_data = ae_alpha;
                    prev_d     = ae_alpha;
                    k_d        = k_next[ADDR_BITS-1:0];
                    state_d    = (k_next == {1'b0, n_q}) ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort beats everything in the same cycle, including a landing result.
        if (abort && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            k_d         = k_q;
            prev_d      = prev_q;
            done        = 1'b0;
            bm_rd_en    = 1'b0;
            bm_rd_addr  = '0;
            ae_in_valid = 1'b0;
            am_wr_en    = 1'b0;
            am_wr_addr  = '0;
            am_wr_data  = '0;
        end
    end

    assign busy             = (state_q != ST_IDLE);
    assign ae_branch_metric = bm_rd_data;
    assign ae_prev_alpha    = prev_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_alpha_recursion_ctrl.sv
// Directed bench for alpha_recursion_ctrl: behavioural memory/element models and
// a scoreboard predicting the alpha write stream from the recursion definition.
module tb_alpha_recursion_ctrl;
    import turbo_ctrl_pkg::*;

    localparam int BITS = 16;
    localparam int STATES = 4;
    localparam int OS = 4;
    localparam int AB = 10;
    localparam int WW = AB + 1 + STATES * BITS;

    logic clk, rst_n, start, abort;
    logic [AB-1:0] frame_len;
    alpha_t alpha_init;
    logic busy, done, bm_rd_en, ae_in_valid, ae_out_valid, am_wr_en;
    logic [AB-1:0] bm_rd_addr;
    branch_metric_t bm_rd_data, ae_branch_metric;
    alpha_t ae_prev_alpha, ae_alpha, am_wr_data;
    logic [AB:0] am_wr_addr;
    state_e dbg_state;

    alpha_recursion_ctrl #(.BITS(BITS), .STATES(STATES), .OUTPUT_SYMBOLS(OS), .ADDR_BITS(AB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .frame_len(frame_len), .alpha_init(alpha_init),
        .busy(busy), .done(done),
        .bm_rd_en(bm_rd_en), .bm_rd_addr(bm_rd_addr), .bm_rd_data(bm_rd_data),
        .ae_in_valid(ae_in_valid), .ae_branch_metric(ae_branch_metric), .ae_prev_alpha(ae_prev_alpha),
        .ae_out_valid(ae_out_valid), .ae_alpha(ae_alpha),
        .am_wr_en(am_wr_en), .am_wr_addr(am_wr_addr), .am_wr_data(am_wr_data),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [WW-1:0]  exp_q[$];
    logic [127:0]   exp_iss_q[$];
    logic [AB-1:0]  exp_bm_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int exp_done_cyc = -1;
    int done_cnt = 0;
    int last_done_cyc = -1;

    branch_metric_t bm_mem [0:1023];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    // Recursion rule used by the element model: new[s] = prev[s+1 mod S] + bm[s].
    function automatic alpha_t model_step(input alpha_t p, input branch_metric_t b);
        alpha_t r;
        for (int s = 0; s < STATES; s++) r[s] = p[(s + 1) % STATES] + b[s % OS];
        return r;
    endfunction

    // ---------------- branch-metric memory model ----------------
    logic bm_pend = 1'b0;
    logic [AB-1:0] bm_addr_l = '0;
    always @(negedge clk) begin
        if (rst_n && bm_rd_en) begin
            bm_pend = 1'b1;
            bm_addr_l = bm_rd_addr;
        end
    end
    initial begin
        bm_rd_data = {4{16'hDEAD}};
        forever begin
            @(posedge clk);
            #1;
            bm_rd_data = bm_pend ? bm_mem[bm_addr_l] : {4{16'hDEAD}};
            bm_pend = 1'b0;
        end
    end

    // ---------------- alpha element model (latency ae_lat) ----------------
    int ae_lat = 1;
    int pend_cnt = 0;
    alpha_t pend_data;
    always @(negedge clk) begin
        if (rst_n && ae_in_valid) begin
            pend_cnt = ae_lat;
            pend_data = model_step(ae_prev_alpha, ae_branch_metric);
        end
    end
    initial begin
        ae_out_valid = 1'b0;
        ae_alpha = '0;
        forever begin
            @(posedge clk);
            #1;
            ae_out_valid = 1'b0;
            ae_alpha = {4{16'h5A5A}};
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    ae_out_valid = 1'b1;
                    ae_alpha = pend_data;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (am_wr_en) begin
                if (exp_q.size() == 0) flag("am_write_extra");
                else check("am_write", {am_wr_addr, am_wr_data}, exp_q.pop_front());
            end
            if (ae_in_valid) begin
                if (exp_iss_q.size() == 0) flag("ae_issue_extra");
                else check("ae_issue", {ae_prev_alpha, ae_branch_metric}, exp_iss_q.pop_front());
            end
            if (bm_rd_en) begin
                if (exp_bm_q.size() == 0) flag("bm_read_extra");
                else check("bm_read_addr", bm_rd_addr, exp_bm_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
                check("done_cycle", cyc, exp_done_cyc);
            end
            if (!busy) check("idle_strobes", {bm_rd_en, ae_in_valid, am_wr_en, done}, 4'b0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_case(input int n, input int lat, input int abort_step, input bit repulse,
                            input alpha_t init, output int c0);
        alpha_t a;
        int steps, done_c, abort_c, end_c;
        ae_lat = lat;
        @(posedge clk);
        #1;
        c0 = cyc;
        frame_len = AB'(n);
        alpha_init = init;
        start = 1'b1;
        a = init;
        exp_q.push_back({(AB+1)'(0), a});
        steps = (abort_step >= 0) ? abort_step + 1 : n;
        for (int i = 0; i < steps; i++) begin
            exp_bm_q.push_back(AB'(i));
            exp_iss_q.push_back({a, bm_mem[i]});
            a = model_step(a, bm_mem[i]);
            if (i != abort_step) exp_q.push_back({(AB+1)'(i + 1), a});
        end
        done_c = c0 + n * (lat + 2) + 2;
        abort_c = c0 + 3 + abort_step * (lat + 2) + lat;
        exp_done_cyc = (abort_step >= 0) ? -1 : done_c;
        end_c = (abort_step >= 0) ? abort_c : done_c;
        done_cnt = 0;
        while (cyc < end_c + 3) begin
            @(posedge clk);
            #1;
            start = repulse && (cyc == c0 + 5 || cyc == done_c);
            frame_len = AB'($urandom_range(0, 1023));
            alpha_init = {4{16'(($urandom_range(0, 65535)))}};
            abort = (abort_step >= 0) && (cyc == abort_c);
            if (abort_step >= 0 && cyc == abort_c + 1) check("abort_idle", dbg_state, ST_IDLE);
        end
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("end_busy", busy, 1'b0);
        check("done_count", done_cnt, (abort_step >= 0) ? 0 : 1);
        check("writes_left", exp_q.size(), 0);
        check("issues_left", exp_iss_q.size(), 0);
        check("reads_left", exp_bm_q.size(), 0);
        exp_q.delete();
        exp_iss_q.delete();
        exp_bm_q.delete();
        exp_done_cyc = -1;
    endtask

    // ---------------- main sequence ----------------
    alpha_t init0;
    int c0;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        frame_len = '0;
        alpha_init = '0;
        for (int i = 0; i < 1024; i++)
            for (int s = 0; s < OS; s++) bm_mem[i][s] = 16'(16'h0100 * (i + 1) + s);
        init0 = {16'h0000, 16'hFBFF, 16'hFBFF, 16'hFBFF};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {busy, done, bm_rd_en, ae_in_valid, am_wr_en, bm_rd_addr, am_wr_addr, ae_prev_alpha},
              '0);
        check("reset_state", dbg_state, ST_IDLE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // pin the model with a hand-computed first recursion step
        check("model_pin", model_step(init0, bm_mem[0]), 64'hFD02_0102_FD00_FCFF);

        run_case(4, 1, -1, 1'b0, init0, c0);
        check("n4_done_at_14", last_done_cyc - c0, 14);

        run_case(0, 1, -1, 1'b0, init0, c0);
        check("n0_done_at_2", last_done_cyc - c0, 2);

        run_case(3, 5, -1, 1'b0, {16'h1234, 16'h0001, 16'hFFFF, 16'h8000}, c0);
        check("n3_lat5_done", last_done_cyc - c0, 23);

        run_case(4, 1, 2, 1'b0, init0, c0);

        run_case(5, 1, -1, 1'b1, {16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0}, c0);
        check("n5_done_at_17", last_done_cyc - c0, 17);

        run_case(1, 2, -1, 1'b0, {16'h7FFF, 16'h0002, 16'h0003, 16'h0004}, c0);

        // reset in the middle of FETCH of step 0
        @(posedge clk);
        #1;
        frame_len = AB'(8);
        alpha_init = init0;
        start = 1'b1;
        exp_q.push_back({(AB+1)'(0), init0});
        exp_done_cyc = -1;
        done_cnt = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("fetch_before_reset", {bm_rd_en, dbg_state}, {1'b1, ST_FETCH});
        rst_n = 1'b0;
        #1;
        check("reset_mid_fetch", {busy, done, bm_rd_en, ae_in_valid, am_wr_en, bm_rd_addr, am_wr_addr}, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("no_done_after_reset", done_cnt, 0);
        check("reset_writes_left", exp_q.size(), 0);
        exp_q.delete();

        run_case(2, 1, -1, 1'b0, init0, c0);
        check("post_reset_done", last_done_cyc - c0, 8);

        run_case(1023, 1, -1, 1'b0, init0, c0);
        check("max_n_done", last_done_cyc - c0, 3 * 1023 + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
